// File: rtl/pipe_pkg.sv
// Shared types and constants for the fetch-stage next-PC logic.
package pipe_pkg;

    localparam int unsigned PC_W = 32;
    localparam logic [PC_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_BR   = 3'd1,
        SEL_JR   = 3'd2,
        SEL_J    = 3'd3,
        SEL_HOLD = 3'd4
    } sel_t;

    function automatic logic [PC_W-1:0] jump_target(input logic [3:0]  region,
                                                    input logic [25:0] index);
        return {region, index, 2'b00};
    endfunction

endpackage

// File: rtl/pc_target_mux.sv
// Priority select of the next fetch address and redirect alignment flag.
module pc_target_mux
    import pipe_pkg::*;
(
    input  logic        branch,
    input  logic [31:0] branch_pc,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    input  logic        stall,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic [3:0]  jump_region,
    input  logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    output sel_t        sel,
    output logic [31:0] target,
    output logic        ex_redirect,
    output logic        misaligned
);

    // EX redirects outrank Stall: the stalled ID instruction is younger and dies anyway.
    always_comb begin
        sel    = SEL_SEQ;
        target = pc_plus4;
        if (branch) begin
            sel    = SEL_BR;
            target = branch_pc;
        end else if (jump_reg) begin
            sel    = SEL_JR;
            target = reg_target;
        end else if (stall) begin
            sel    = SEL_HOLD;
            target = pc;
        end else if (jump) begin
            sel    = SEL_J;
            target = jump_target(jump_region, jump_index);
        end
    end

    assign ex_redirect = (sel == SEL_BR) || (sel == SEL_JR);
    assign misaligned  = (ex_redirect || (sel == SEL_J)) && (target[1:0] != 2'b00);

endmodule

// File: rtl/pc_next_unit.sv
// Fetch-stage program counter: owns the PC register, redirect sequencing and squash strobes.
//
//   state | meaning
//   BOOT  | one cycle after reset, PC held, fetch not valid
//   RUN   | normal fetch, redirects and stalls honoured
//   HALT  | misaligned redirect trapped, PC frozen until reset
module pc_next_unit
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Branch,
    input  logic [ADDR_W-1:0] BranchPC,
    input  logic              JumpReg,
    input  logic [ADDR_W-1:0] RegTarget,
    input  logic              Jump,
    input  logic [25:0]       JumpIndex,
    input  logic [ADDR_W-1:0] IdPCPlus4,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PCPlus4,
    output logic              FetchValid,
    output logic              SquashIF,
    output logic              SquashID,
    output logic              AddrErr
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        addr_err_q, addr_err_d;

    sel_t        sel;
    logic [31:0] target;
    logic        ex_redirect;
    logic        misaligned;
    logic [31:0] pc_plus4;

    // Only the region bits of the ID-stage PCPlus4 feed the jump target.
    logic unused_id_low;
    assign unused_id_low = ^IdPCPlus4[27:0];

    assign pc_plus4 = pc_q + PC_STEP;

    pc_target_mux u_mux (
        .branch      (Branch),
        .branch_pc   (BranchPC),
        .jump_reg    (JumpReg),
        .reg_target  (RegTarget),
        .stall       (Stall),
        .jump        (Jump),
        .jump_index  (JumpIndex),
        .jump_region (IdPCPlus4[31:28]),
        .pc          (pc_q),
        .pc_plus4    (pc_plus4),
        .sel         (sel),
        .target      (target),
        .ex_redirect (ex_redirect),
        .misaligned  (misaligned)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_err_d = addr_err_q;
        FetchValid = 1'b0;
        SquashIF   = 1'b0;
        SquashID   = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                FetchValid = 1'b1;
                SquashIF   = ex_redirect || (sel == SEL_J);
                SquashID   = ex_redirect;
                // A bad target traps on this edge; the PC keeps the faulting fetch address.
                if (misaligned) begin
                    state_d    = HALT;
                    addr_err_d = 1'b1;
                end else begin
                    pc_d = target;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign PC      = pc_q;
    assign PCPlus4 = pc_plus4;
    assign AddrErr = addr_err_q;

endmodule
